// File: rtl/calc2_pkg.sv
// Shared types and defaults for the calc2 responder.
// The optional duplicate-tag check (CALC2_RESP_TAG_CHECK_EN) lives in the responder and FIFO.
package calc2_pkg;

  typedef enum logic [3:0] {
    CMD_IDLE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef struct packed {
    resp_e       resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } resp_entry_t;

  localparam int ARITH_LAT_DEF  = 2;
  localparam int SHIFT_LAT_DEF  = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam resp_entry_t RESP_IDLE = '{resp: RESP_NONE, data: 32'd0, tag: 2'd0};

endpackage

// File: rtl/calc2_resp_fifo.sv
// Response FIFO: two write ports (port 0 lands first), one pop per cycle, sticky overflow.
// With CALC2_RESP_TAG_CHECK_EN an ownership bit travels alongside each entry.
module calc2_resp_fifo
  import calc2_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        w0_vld,
  input  resp_entry_t w0_data,
  input  logic        w1_vld,
  input  resp_entry_t w1_data,
`ifdef CALC2_RESP_TAG_CHECK_EN
  input  logic        w0_own,
  input  logic        w1_own,
  output logic        head_own,
`endif
  input  logic        pop,
  output logic        empty,
  output resp_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  resp_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          acc0, acc1, do_pop;
  int            avail;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A slot freed by this cycle's pop is reusable by this cycle's writes.
  always_comb begin
    do_pop = pop && (cnt != '0);
    avail  = DEPTH - int'(cnt) + (do_pop ? 1 : 0);
    acc0   = w0_vld && (avail >= 1);
    acc1   = w1_vld && (avail >= (acc0 ? 2 : 1));
  end

  always_ff @(posedge c_clk) begin
    if (acc0) mem[wr_ptr] <= w0_data;
    if (acc1) mem[acc0 ? inc(wr_ptr) : wr_ptr] <= w1_data;
  end

`ifdef CALC2_RESP_TAG_CHECK_EN
  logic own_mem [DEPTH];
  always_ff @(posedge c_clk) begin
    if (acc0) own_mem[wr_ptr] <= w0_own;
    if (acc1) own_mem[acc0 ? inc(wr_ptr) : wr_ptr] <= w1_own;
  end
  assign head_own = own_mem[rd_ptr];
`endif

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (acc0 && acc1)     wr_ptr <= inc(inc(wr_ptr));
      else if (acc0 || acc1) wr_ptr <= inc(wr_ptr);
      if (do_pop) rd_ptr <= inc(rd_ptr);
      cnt <= cnt + CW'(acc0) + CW'(acc1) - CW'(do_pop);
      ovf <= ovf | (w0_vld & ~acc0) | (w1_vld & ~acc1);
    end
  end

  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/calc2_responder.sv
// calc2 responder: two-cycle request capture, arith/shift pipelines, completion-order responses.
// Define CALC2_RESP_TAG_CHECK_EN to reject requests whose tag is still outstanding.
module calc2_responder
  import calc2_pkg::*;
#(
  parameter int ARITH_LAT  = ARITH_LAT_DEF,
  parameter int SHIFT_LAT  = SHIFT_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag
);

  typedef enum logic {ST_IDLE, ST_OP2} state_e;

  state_e      state, state_nxt;
  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [1:0]  tag_q;
  logic        issue, dup, is_shift, empty;
  logic [32:0] sum;
  resp_entry_t ar_res, sh_res, head;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: if (req_cmd_in != CMD_IDLE) state_nxt = ST_OP2;
      ST_OP2: begin
        issue     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q <= '0;
      op1_q <= '0;
      tag_q <= '0;
    end else if (state == ST_IDLE && req_cmd_in != CMD_IDLE) begin
      cmd_q <= req_cmd_in;
      op1_q <= req_data_in;
      tag_q <= req_tag_in;
    end
  end

`ifdef CALC2_RESP_TAG_CHECK_EN
  logic [3:0] outstanding, set_mask, clr_mask;
  logic       head_own;

  // Only the request that set a tag's bit may clear it; a rejected duplicate never owns it.
  always_comb begin
    set_mask = (issue && !dup) ? (4'd1 << tag_q) : 4'd0;
    clr_mask = (!empty && head_own) ? (4'd1 << head.tag) : 4'd0;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) outstanding <= '0;
    else        outstanding <= (outstanding & ~clr_mask) | set_mask;
  end
`endif

  // Result is formed from op1 and the live op2 word on the issue cycle.
  always_comb begin
    dup = 1'b0;
`ifdef CALC2_RESP_TAG_CHECK_EN
    dup = outstanding[tag_q];
`endif
    sum      = {1'b0, op1_q} + {1'b0, req_data_in};
    is_shift = !dup && (cmd_q == CMD_SHL || cmd_q == CMD_SHR);
    ar_res      = RESP_IDLE;
    ar_res.resp = RESP_ERR;
    ar_res.tag  = tag_q;
    if (!dup) begin
      case (cmd_q)
        CMD_ADD: if (!sum[32]) begin
          ar_res.resp = RESP_OK;
          ar_res.data = sum[31:0];
        end
        CMD_SUB: if (req_data_in <= op1_q) begin
          ar_res.resp = RESP_OK;
          ar_res.data = op1_q - req_data_in;
        end
        default: ;
      endcase
    end
    sh_res.resp = RESP_OK;
    sh_res.tag  = tag_q;
    sh_res.data = (cmd_q == CMD_SHL) ? (op1_q << req_data_in[4:0]) : (op1_q >> req_data_in[4:0]);
  end

  // Stage 0 is the issue cycle itself; stage LAT-1 writes the FIFO on edge T+LAT-1.
  for (genvar i = 0; i < ARITH_LAT; i++) begin : g_ar
    logic        v;
    resp_entry_t e;
`ifdef CALC2_RESP_TAG_CHECK_EN
    logic        o;
`endif
    if (i == 0) begin : g_in
      assign v = issue && !is_shift;
      assign e = ar_res;
`ifdef CALC2_RESP_TAG_CHECK_EN
      assign o = !dup;
`endif
    end else begin : g_reg
      always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
          v <= 1'b0;
          e <= RESP_IDLE;
`ifdef CALC2_RESP_TAG_CHECK_EN
          o <= 1'b0;
`endif
        end else begin
          v <= g_ar[i-1].v;
          e <= g_ar[i-1].e;
`ifdef CALC2_RESP_TAG_CHECK_EN
          o <= g_ar[i-1].o;
`endif
        end
      end
    end
  end

  for (genvar i = 0; i < SHIFT_LAT; i++) begin : g_sh
    logic        v;
    resp_entry_t e;
    if (i == 0) begin : g_in
      assign v = issue && is_shift;
      assign e = sh_res;
    end else begin : g_reg
      always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
          v <= 1'b0;
          e <= RESP_IDLE;
        end else begin
          v <= g_sh[i-1].v;
          e <= g_sh[i-1].e;
        end
      end
    end
  end

  calc2_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .c_clk   (c_clk),
    .reset   (reset),
    .w0_vld  (g_ar[ARITH_LAT-1].v),
    .w0_data (g_ar[ARITH_LAT-1].e),
    .w1_vld  (g_sh[SHIFT_LAT-1].v),
    .w1_data (g_sh[SHIFT_LAT-1].e),
`ifdef CALC2_RESP_TAG_CHECK_EN
    .w0_own  (g_ar[ARITH_LAT-1].o),
    .w1_own  (1'b1),
    .head_own(head_own),
`endif
    .pop     (1'b1),
    .empty   (empty),
    .head    (head)
  );

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else if (!empty) begin
      out_resp <= head.resp;
      out_data <= head.data;
      out_tag  <= head.tag;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end
  end

endmodule

// File: tb/tb_calc2_responder.sv
// Directed bench for calc2_responder; exercises CALC2_RESP_TAG_CHECK_EN when defined.
module tb_calc2_responder;
  import calc2_pkg::*;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_cmd_in = '0;
  logic [31:0] req_data_in = '0;
  logic [1:0]  req_tag_in = '0;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;

  int checks = 0;
  int errors = 0;

  always #5 c_clk = ~c_clk;

  calc2_responder dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .req_tag_in (req_tag_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .out_tag    (out_tag)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] r, input logic [31:0] d,
                         input logic [1:0] t);
    chk({name, "_resp"}, {30'd0, out_resp}, {30'd0, r});
    chk({name, "_data"}, out_data, d);
    chk({name, "_tag"},  {30'd0, out_tag},  {30'd0, t});
  endtask

  // Set inputs, then advance to the next negedge.
  task automatic drive(input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    req_cmd_in  = c;
    req_data_in = d;
    req_tag_in  = t;
    @(negedge c_clk);
  endtask

  // Returns on the negedge just after the op2 edge T (offset 0).
  task automatic send(input logic [3:0] c, input logic [31:0] op1, input logic [1:0] t,
                      input logic [31:0] op2);
    drive(c, op1, t);
    drive(4'd0, op2, 2'd0);
    req_data_in = '0;
  endtask

  task automatic expect_win(input string name, input int lat, input logic [1:0] r,
                            input logic [31:0] d, input logic [1:0] t);
    for (int k = 0; k <= lat + 1; k++) begin
      if (k == lat) chk_out(name, r, d, t);
      else          chk_out({name, "_quiet"}, 2'd0, 32'd0, 2'd0);
      @(negedge c_clk);
    end
  endtask

  // First request's op2 at T0, second's op2 at T0+2; expect a at T0+4 and b at T0+5.
  task automatic pair(input string name,
                      input logic [3:0] c1, input logic [31:0] o1, input logic [1:0] t1,
                      input logic [31:0] p1,
                      input logic [3:0] c2, input logic [31:0] o2, input logic [1:0] t2,
                      input logic [31:0] p2,
                      input logic [1:0] ra, input logic [31:0] da, input logic [1:0] ta,
                      input logic [1:0] rb, input logic [31:0] db, input logic [1:0] tb);
    drive(c1, o1, t1);
    drive(4'd0, p1, 2'd0);
    chk_out({name, "_q0"}, 2'd0, 32'd0, 2'd0);
    drive(c2, o2, t2);
    chk_out({name, "_q1"}, 2'd0, 32'd0, 2'd0);
    drive(4'd0, p2, 2'd0);
    req_data_in = '0;
    for (int k = 2; k <= 6; k++) begin
      if (k == 4)      chk_out({name, "_a"}, ra, da, ta);
      else if (k == 5) chk_out({name, "_b"}, rb, db, tb);
      else             chk_out({name, "_quiet"}, 2'd0, 32'd0, 2'd0);
      @(negedge c_clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge c_clk);
    chk_out("reset", 2'd0, 32'd0, 2'd0);
    chk("reset_ovf", {31'd0, dut.u_fifo.ovf}, 32'd0);
    reset = 1'b1;

    // Command sampled on the first edge after release.
    send(4'd1, 32'h30, 2'd1, 32'h20);        expect_win("add", 2, 2'd1, 32'h50, 2'd1);
    send(4'd2, 32'h10, 2'd2, 32'h20);        expect_win("sub_uf", 2, 2'd2, 32'd0, 2'd2);
    send(4'd2, 32'h20, 2'd0, 32'h10);        expect_win("sub", 2, 2'd1, 32'h10, 2'd0);
    send(4'd2, 32'h77, 2'd3, 32'h77);        expect_win("sub_eq", 2, 2'd1, 32'd0, 2'd3);
    send(4'd5, 32'h1, 2'd1, 32'h24);         expect_win("shl", 4, 2'd1, 32'h10, 2'd1);
    send(4'd6, 32'h8000_0000, 2'd2, 32'd31); expect_win("shr", 4, 2'd1, 32'h1, 2'd2);
    send(4'd1, 32'hFFFF_FFFF, 2'd3, 32'h1);  expect_win("add_co", 2, 2'd2, 32'd0, 2'd3);
    send(4'd1, 32'hFFFF_FFFE, 2'd0, 32'h1);  expect_win("add_max", 2, 2'd1, 32'hFFFF_FFFF, 2'd0);
    send(4'd3, 32'h5, 2'd1, 32'h5);          expect_win("inv3", 2, 2'd2, 32'd0, 2'd1);
    send(4'd15, 32'h5, 2'd2, 32'h5);         expect_win("inv15", 2, 2'd2, 32'd0, 2'd2);

    // Shift issued first, add two cycles later: both complete together, add pops first.
    pair("reorder", 4'd5, 32'h3, 2'd0, 32'h2, 4'd1, 32'h11, 2'd1, 32'h22,
         2'd1, 32'h33, 2'd1, 2'd1, 32'hC, 2'd0);

`ifdef CALC2_RESP_TAG_CHECK_EN
    pair("dup", 4'd5, 32'h1, 2'd3, 32'h1, 4'd1, 32'h1, 2'd3, 32'h1,
         2'd2, 32'd0, 2'd3, 2'd1, 32'h2, 2'd3);
    send(4'd1, 32'h3, 2'd3, 32'h4);          expect_win("dup_free", 2, 2'd1, 32'h7, 2'd3);
`else
    pair("dup", 4'd5, 32'h1, 2'd3, 32'h1, 4'd1, 32'h1, 2'd3, 32'h1,
         2'd1, 32'h2, 2'd3, 2'd1, 32'h2, 2'd3);
`endif

    // Reset while a shift is in flight: nothing may emerge afterwards.
    drive(4'd5, 32'h1, 2'd0);
    drive(4'd0, 32'h4, 2'd0);
    req_data_in = '0;
    reset = 1'b0;
    #1 chk_out("rst_mid", 2'd0, 32'd0, 2'd0);
    @(negedge c_clk);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      chk_out("rst_quiet", 2'd0, 32'd0, 2'd0);
      @(negedge c_clk);
    end
    send(4'd1, 32'h5, 2'd0, 32'h7);          expect_win("post_rst", 2, 2'd1, 32'hC, 2'd0);

    chk("ovf", {31'd0, dut.u_fifo.ovf}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
